// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the ID-stage control path: opcodes, bundle bit positions,
// ALUOp encodings and the per-instruction control bundles.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int BIT_REG_WRITE  = 7;
    localparam int BIT_MEM_TO_REG = 6;
    localparam int BIT_MEM_READ   = 5;
    localparam int BIT_MEM_WRITE  = 4;
    localparam int BIT_ALU_SRC    = 3;
    localparam int BIT_ALU_OP_HI  = 2;
    localparam int BIT_ALU_OP_LO  = 1;
    localparam int BIT_REG_DST    = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}
    localparam logic [7:0] CTRL_RTYPE = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT, 1'b1};
    localparam logic [7:0] CTRL_ADDI  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD,   1'b0};
    localparam logic [7:0] CTRL_LW    = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ALUOP_ADD,   1'b0};
    localparam logic [7:0] CTRL_SW    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALUOP_ADD,   1'b0};
    localparam logic [7:0] CTRL_BEQ   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_SUB,   1'b0};
    localparam logic [7:0] CTRL_J     = 8'h00;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode decoder: control bundle, source-register usage,
// branch/jump flags and unsupported-opcode detection.
module id_ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [7:0]  bundle,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        is_beq,
    output logic        is_j,
    output logic        illegal
);

    always_comb begin
        bundle  = 8'h00;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        illegal = 1'b0;
        // An all-zero word is a nop, not an R-type writing $0.
        if (instr != 32'h0) begin
            case (instr[31:26])
                OP_RTYPE: begin bundle = CTRL_RTYPE; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_ADDI:  begin bundle = CTRL_ADDI;  uses_rs = 1'b1; end
                OP_LW:    begin bundle = CTRL_LW;    uses_rs = 1'b1; end
                OP_SW:    begin bundle = CTRL_SW;    uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_BEQ:   begin bundle = CTRL_BEQ;   uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; end
                OP_J:     begin bundle = CTRL_J;     is_j = 1'b1; end
                default:  illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage control producer: decode, load-use/branch hazard stall, branch/jump
// resolution, IF flush and saturating stall/flush counters.
module id_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             rs_eq_rt_i,
    output logic [7:0]       pipeline_info_o,
    output logic [4:0]       RSaddr_o,
    output logic [4:0]       RTaddr_o,
    output logic [4:0]       RDaddr_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFFlush_o,
    output logic             branch_taken_o,
    output logic             jump_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [7:0] bundle;
    logic       uses_rs, uses_rt, is_beq, is_j, dec_illegal;

    id_ctrl_decode u_decode (
        .instr   (instr_i),
        .bundle  (bundle),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .is_beq  (is_beq),
        .is_j    (is_j),
        .illegal (dec_illegal)
    );

    logic [4:0] rs, rt, rd, dst;
    assign rs  = instr_i[25:21];
    assign rt  = instr_i[20:16];
    assign rd  = instr_i[15:11];
    assign dst = bundle[BIT_REG_DST] ? rd : rt;

    assign RSaddr_o = rs;
    assign RTaddr_o = rt;
    assign RDaddr_o = rd;

    // Mirrors of what is now in EX and MEM; bubbles travel as zeros.
    logic       ex_reg_write, ex_mem_read, mem_mem_read;
    logic [4:0] ex_dst, mem_dst;

    logic ex_hits_rs, ex_hits_rt, mem_hits_any;
    logic load_use, branch_haz, stall, go;
    logic [7:0] issued;

    assign ex_hits_rs   = (ex_dst != 5'd0) && (ex_dst == rs);
    assign ex_hits_rt   = (ex_dst != 5'd0) && (ex_dst == rt);
    assign mem_hits_any = (mem_dst != 5'd0) && ((mem_dst == rs) || (mem_dst == rt));

    assign load_use   = ex_mem_read && ((uses_rs && ex_hits_rs) || (uses_rt && ex_hits_rt));
    assign branch_haz = is_beq && ((ex_reg_write && (ex_hits_rs || ex_hits_rt)) ||
                                   (mem_mem_read && mem_hits_any));
    assign stall      = !rst_i && (load_use || branch_haz);
    assign go         = !rst_i && !stall;
    assign issued     = go ? bundle : 8'h00;

    assign pipeline_info_o = issued;
    assign PCWrite_o       = go;
    assign IFIDWrite_o     = go;
    assign branch_taken_o  = go && is_beq && rs_eq_rt_i;
    assign jump_o          = go && is_j;
    assign IFFlush_o       = branch_taken_o || jump_o;

    logic             illegal_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_dst       <= 5'd0;
            mem_mem_read <= 1'b0;
            mem_dst      <= 5'd0;
            illegal_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_reg_write <= issued[BIT_REG_WRITE];
            ex_mem_read  <= issued[BIT_MEM_READ];
            ex_dst       <= go ? dst : 5'd0;
            mem_mem_read <= ex_mem_read;
            mem_dst      <= ex_dst;
            illegal_q    <= illegal_q || dec_illegal;
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (IFFlush_o && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign illegal_o   = !rst_i && illegal_q;
    assign stall_cnt_o = rst_i ? '0 : stall_cnt_q;
    assign flush_cnt_o = rst_i ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus randomized instruction
// streams checked against a history-based model of the issue rules.
module tb_id_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] instr_i = 32'h0;
    logic        rs_eq_rt_i = 1'b0;
    logic [7:0]  pipeline_info_o;
    logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
    logic        PCWrite_o, IFIDWrite_o, IFFlush_o, branch_taken_o, jump_o, illegal_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    id_hazard_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .rs_eq_rt_i(rs_eq_rt_i),
        .pipeline_info_o(pipeline_info_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o),
        .RDaddr_o(RDaddr_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
        .IFFlush_o(IFFlush_o), .branch_taken_o(branch_taken_o), .jump_o(jump_o),
        .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: the two most recently issued instructions (front = EX, back = MEM).
    typedef struct packed { logic writes; logic loads; logic [4:0] dst; } issued_t;
    issued_t hist_q[$];
    logic [15:0] m_scnt, m_fcnt;
    logic        m_ill, m_ill_now, m_rst;
    logic [4:0]  m_dst;
    logic [7:0]  e_info;
    logic        e_stall, e_go, e_bt, e_j, e_fl;
    logic [47:0] e_vec, a_vec;

    task automatic model_reset();
        hist_q = {};
        hist_q.push_back('0);
        hist_q.push_back('0);
        m_scnt = 16'h0; m_fcnt = 16'h0; m_ill = 1'b0;
    endtask

    task automatic model_eval();
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [7:0] b;
        logic urs, urt, beq, jmp, lu, bh;
        issued_t ex, mem;
        op = instr_i[31:26]; rs = instr_i[25:21]; rt = instr_i[20:16]; rd = instr_i[15:11];
        b = 8'h00; urs = 0; urt = 0; beq = 0; jmp = 0; m_ill_now = 0;
        if (instr_i != 32'h0) begin
            case (op)
                6'h00: begin b = 8'h85; urs = 1; urt = 1; end
                6'h08: begin b = 8'h88; urs = 1; end
                6'h23: begin b = 8'hE8; urs = 1; end
                6'h2B: begin b = 8'h18; urs = 1; urt = 1; end
                6'h04: begin b = 8'h02; urs = 1; urt = 1; beq = 1; end
                6'h02: jmp = 1;
                default: m_ill_now = 1;
            endcase
        end
        m_dst = (op == 6'h00) ? rd : rt;
        ex = hist_q[0];
        mem = hist_q[1];
        lu = ex.loads && ex.dst != 0 && ((urs && ex.dst == rs) || (urt && ex.dst == rt));
        bh = beq && ((ex.writes && ex.dst != 0 && (ex.dst == rs || ex.dst == rt)) ||
                     (mem.loads && mem.dst != 0 && (mem.dst == rs || mem.dst == rt)));
        m_rst   = rst_i;
        e_stall = !rst_i && (lu || bh);
        e_go    = !rst_i && !e_stall;
        e_info  = e_go ? b : 8'h00;
        e_bt    = e_go && beq && rs_eq_rt_i;
        e_j     = e_go && jmp;
        e_fl    = e_bt || e_j;
        e_vec = {e_info, e_go, e_go, e_fl, e_bt, e_j, (!rst_i && m_ill),
                 (rst_i ? 16'h0 : m_scnt), (rst_i ? 16'h0 : m_fcnt)};
    endtask

    task automatic model_commit();
        issued_t rec;
        if (m_rst) begin
            model_reset();
        end else begin
            rec.writes = e_info[7];
            rec.loads  = e_info[5];
            rec.dst    = e_go ? m_dst : 5'd0;
            hist_q.push_front(rec);
            void'(hist_q.pop_back());
            if (e_stall && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            if (e_fl && m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
            m_ill = m_ill || m_ill_now;
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic apply(input logic [31:0] ins, input logic eq, input logic r);
        instr_i = ins; rs_eq_rt_i = eq; rst_i = r;
        #2;
        model_eval();
        a_vec = {pipeline_info_o, PCWrite_o, IFIDWrite_o, IFFlush_o, branch_taken_o,
                 jump_o, illegal_o, stall_cnt_o, flush_cnt_o};
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_commit();
        #1;
    endtask

    task automatic reset_dut();
        apply(32'h0, 1'b0, 1'b1); advance();
        apply(32'h0, 1'b0, 1'b1); advance();
    endtask

    task automatic test_reset();
        apply(32'h20050007, 1'b1, 1'b1);
        checks++;
        if (a_vec !== 48'h0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", a_vec);
        end
        checks++;
        if (RTaddr_o !== 5'd5) begin
            errors++; $display("FAIL reset_addr_passthru got=%0d want=5", RTaddr_o);
        end
        advance();
        apply(32'h20050007, 1'b0, 1'b0);
        checks++;
        if ({pipeline_info_o, RTaddr_o, PCWrite_o, stall_cnt_o} !== {8'h88, 5'd5, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL addi_issue got info=%h rt=%0d pcw=%b scnt=%0d want 88/5/1/0",
                     pipeline_info_o, RTaddr_o, PCWrite_o, stall_cnt_o);
        end
        advance();
    endtask

    task automatic test_load_use();
        reset_dut();
        apply(32'h8C410000, 1'b0, 1'b0);
        checks++;
        if (pipeline_info_o !== 8'hE8) begin
            errors++; $display("FAIL lu_lw_issue got=%h want=e8", pipeline_info_o);
        end
        advance();
        apply(32'h00241820, 1'b0, 1'b0);
        checks++;
        if ({pipeline_info_o, PCWrite_o, IFIDWrite_o} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lu_bubble got info=%h pcw=%b ifid=%b want 00/0/0",
                     pipeline_info_o, PCWrite_o, IFIDWrite_o);
        end
        advance();
        apply(32'h00241820, 1'b0, 1'b0);
        checks++;
        if ({pipeline_info_o, PCWrite_o, stall_cnt_o} !== {8'h85, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL lu_release got info=%h pcw=%b scnt=%0d want 85/1/1",
                     pipeline_info_o, PCWrite_o, stall_cnt_o);
        end
        advance();
    endtask

    task automatic test_lw_beq();
        reset_dut();
        apply(32'h8C410000, 1'b0, 1'b0); advance();
        for (int i = 0; i < 2; i++) begin
            apply(32'h10200003, 1'b1, 1'b0);
            checks++;
            if ({pipeline_info_o, branch_taken_o, IFFlush_o, PCWrite_o} !== 11'h0) begin
                errors++;
                $display("FAIL lw_beq_bubble%0d got info=%h bt=%b fl=%b pcw=%b want all 0",
                         i, pipeline_info_o, branch_taken_o, IFFlush_o, PCWrite_o);
            end
            advance();
        end
        apply(32'h10200003, 1'b1, 1'b0);
        checks++;
        if ({pipeline_info_o, branch_taken_o, IFFlush_o, stall_cnt_o} !== {8'h02, 1'b1, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL lw_beq_taken got info=%h bt=%b fl=%b scnt=%0d want 02/1/1/2",
                     pipeline_info_o, branch_taken_o, IFFlush_o, stall_cnt_o);
        end
        advance();
        apply(32'h0, 1'b0, 1'b0);
        checks++;
        if (flush_cnt_o !== 16'd1) begin
            errors++; $display("FAIL lw_beq_flush_cnt got=%0d want=1", flush_cnt_o);
        end
        advance();
    endtask

    task automatic test_alu_beq();
        reset_dut();
        apply(32'h00241820, 1'b0, 1'b0); advance();
        apply(32'h10600002, 1'b0, 1'b0);
        checks++;
        if ({pipeline_info_o, PCWrite_o} !== 9'h0) begin
            errors++; $display("FAIL alu_beq_bubble got info=%h pcw=%b want 00/0", pipeline_info_o, PCWrite_o);
        end
        advance();
        apply(32'h10600002, 1'b0, 1'b0);
        checks++;
        if ({pipeline_info_o, PCWrite_o, branch_taken_o, stall_cnt_o} !== {8'h02, 1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL alu_beq_issue got info=%h pcw=%b bt=%b scnt=%0d want 02/1/0/1",
                     pipeline_info_o, PCWrite_o, branch_taken_o, stall_cnt_o);
        end
        advance();
    endtask

    task automatic test_jump_illegal();
        reset_dut();
        apply(32'h08000010, 1'b0, 1'b0);
        checks++;
        if ({jump_o, IFFlush_o, pipeline_info_o, PCWrite_o} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL jump got j=%b fl=%b info=%h pcw=%b want 1/1/00/1",
                     jump_o, IFFlush_o, pipeline_info_o, PCWrite_o);
        end
        advance();
        apply(32'hFC000000, 1'b0, 1'b0);
        checks++;
        if ({illegal_o, pipeline_info_o} !== 9'h0) begin
            errors++; $display("FAIL illegal_same_cycle got ill=%b info=%h want 0/00", illegal_o, pipeline_info_o);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(32'h20050007, 1'b0, 1'b0);
            checks++;
            if (illegal_o !== 1'b1) begin
                errors++; $display("FAIL illegal_sticky%0d got=%b want=1", i, illegal_o);
            end
            advance();
        end
        reset_dut();
        apply(32'h0, 1'b0, 1'b0);
        checks++;
        if (illegal_o !== 1'b0) begin
            errors++; $display("FAIL illegal_cleared got=%b want=0", illegal_o);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        apply(32'h8C410000, 1'b0, 1'b0); advance();
        apply(32'h00241820, 1'b0, 1'b0);
        checks++;
        if (PCWrite_o !== 1'b0) begin
            errors++; $display("FAIL mid_stall_pre got pcw=%b want=0", PCWrite_o);
        end
        apply(32'h00241820, 1'b0, 1'b1); advance();
        apply(32'h00241820, 1'b0, 1'b0);
        checks++;
        if ({pipeline_info_o, PCWrite_o, stall_cnt_o} !== {8'h85, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL mid_stall_release got info=%h pcw=%b scnt=%0d want 85/1/0",
                     pipeline_info_o, PCWrite_o, stall_cnt_o);
        end
        advance();
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 65540; i++) begin
            apply(32'h08000010, 1'b0, 1'b0);
            advance();
        end
        apply(32'h08000010, 1'b0, 1'b0);
        checks++;
        if (flush_cnt_o !== 16'hFFFF) begin
            errors++; $display("FAIL flush_cnt_saturate got=%h want=ffff", flush_cnt_o);
        end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  op;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 8))
                0, 1: op = 6'h00;
                2:    op = 6'h08;
                3, 4: op = 6'h23;
                5:    op = 6'h2B;
                6, 7: op = 6'h04;
                default: op = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h3F;
            endcase
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 11'($urandom)};
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            apply(ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
            checks++;
            if (a_vec !== e_vec || {RSaddr_o, RTaddr_o, RDaddr_o} !== ins[25:11]) begin
                errors++;
                $display("FAIL random[%0d] instr=%h got=%h want=%h", i, ins, a_vec, e_vec);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        model_commit();
        #1;
        test_reset();
        test_load_use();
        test_lw_beq();
        test_alu_beq();
        test_jump_illegal();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
ID-stage producer for the ID/EX pipeline register. It decodes the IF/ID instruction into the 8-bit control bundle and the RS/RT/RD addresses, and resolves beq/j in ID. It detects load-use and branch-operand hazards using internal pipelined mirrors of the EX and MEM stage destinations. It drives bubble insertion, PC/IF-ID write enables, IF flush, and saturating stall/flush counters.

Parameters:
CNT_W, 16, width of stall_cnt_o and flush_cnt_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
instr_i  in  32  instruction from IF/ID
rs_eq_rt_i  in  1  ID-stage register-file compare (RSdata==RTdata)
pipeline_info_o  out  8  {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst} to ID/EX
RSaddr_o  out  5  instr[25:21]
RTaddr_o  out  5  instr[20:16]
RDaddr_o  out  5  instr[15:11]
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID update enable
IFFlush_o  out  1  zero IF/ID next edge
branch_taken_o  out  1  beq taken this cycle
jump_o  out  1  j this cycle
illegal_o  out  1  sticky: unsupported opcode seen
stall_cnt_o  out  CNT_W  bubbles inserted, saturating
flush_cnt_o  out  CNT_W  flushes issued, saturating

Behaviour:
- Decode (combinational), producing bundle values:
  - R-type (op 000000) = 0x85
  - addi (001000) = 0x88
  - lw (100011) = 0xE8
  - sw (101011) = 0x18
  - beq (000100) = 0x02
  - j (000010) = 0x00
  - instr_i==0 is a nop and yields 0x00.
  - Any other opcode yields 0x00 and sets illegal_o on the next edge; illegal_o is cleared only by reset.
- Destination register: dst = RegDst ? rd : rt. A destination is valid only when RegWrite=1 and dst!=0.
- Mirrors (registered every cycle, reset 0):
  - ex_* ← issued bundle/dst
  - mem_* ← ex_*
  - Fields held per stage: RegWrite, MemRead, dst.
  - "Issued" means after bubble muxing, so a bubble mirrors as zeros.
- Source use:
  - rs is used by R-type, addi, lw, sw, beq.
  - rt is used by R-type, sw, beq.
- Load-use hazard: ex_MemRead && ex_dst!=0 && ex_dst matches a used source.
- Branch hazard (beq only):
  - ex_RegWrite && ex_dst!=0 && ex_dst matches rs/rt, or
  - mem_MemRead && mem_dst!=0 && mem_dst matches rs/rt.
  - Result: lw→beq costs 2 bubbles; ALU-op→beq costs 1 bubble.
- stall = load-use OR branch hazard. When stall=1:
  - pipeline_info_o=0x00
  - PCWrite_o=0, IFIDWrite_o=0
  - branch_taken_o, jump_o, IFFlush_o all 0
  - Address outputs still follow instr_i.
- When stall=0:
  - PCWrite_o=IFIDWrite_o=1
  - branch_taken_o = beq && rs_eq_rt_i
  - jump_o = j
  - IFFlush_o = branch_taken_o | jump_o
- Counters increment on each edge where stall (resp. IFFlush_o) is 1, and saturate at all-ones.
- During rst_i=1:
  - All outputs 0 except address passthrough.
  - Mirrors, counters and illegal_o clear on the edge.
  - Reset mid-stall drops the hazard the following cycle, because the mirrors are zero.
- Hazard logic is zero-latency: the decision is made in the same cycle instr_i is presented.
- Simultaneous beq-taken and hazard: the hazard wins, and the branch is re-evaluated after the bubble(s).

Decomposition:
- Package pipe_ctrl_pkg:
  - opcode constants
  - bundle bit-index constants
  - ALUOp encodings (00 add, 01 sub, 10 funct)
  - the six bundle constants above
- Sub-module id_ctrl_decode: combinational opcode→bundle/uses_rs/uses_rt/illegal.
- Mirrors, hazard logic and counters stay in the top module.

Test Plan:
1. Reset, then addi $5,$0,7 (0x20050007) → pipeline_info_o=0x88, RTaddr_o=5, PCWrite_o=1, stall_cnt_o=0.
2. lw $1,0($2) (0x8C410000) then add $3,$1,$4 (0x00241820) held → cycle 1 0xE8; cycle 2 0x00 with PCWrite_o=IFIDWrite_o=0; cycle 3 0x85; stall_cnt_o=1.
3. lw $1 then beq $1,$0 (0x10200003) held, rs_eq_rt_i=1 → two bubbles, then branch_taken_o=IFFlush_o=1; stall_cnt_o=2, flush_cnt_o=1.
4. add $3,$1,$4 then beq with rs=3 (0x10600002) held → exactly one bubble, then 0x02 issued.
5. j 0x08000010 → jump_o=1, IFFlush_o=1, pipeline_info_o=0x00, no stall. Opcode 0x3F → illegal_o=1 from the next cycle, held until rst_i.
6. rst_i asserted during the lw→add stall → next cycle after release, add issues 0x85 with no bubble. Also preload a counter at max → it holds at 0xFFFF.
